seq_divider: RTL and testbench
==============================

# seq_divider

Sequential restoring divider that performs unsigned integer division of two WIDTH-bit operands, producing one quotient bit per clock cycle. It is the inverse-operation companion to the team's shift-add multiplier and uses the same start/done handshake, so both arithmetic units can be driven by the same sequencer. Control FSM and datapath are split, matching the multiplier's control/datapath partitioning.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- dividend  input  WIDTH  numerator; sampled with start
- divisor  input  WIDTH  denominator; sampled with start
- busy  output  1  high from cycle after accepted start until done cycle inclusive
- done  output  1  single-cycle pulse; results valid
- quotient  output  WIDTH  result; held until next accepted start
- remainder  output  WIDTH  result; held until next accepted start
- div_by_zero  output  1  set with done when divisor==0; held with results

## Operation
- Reset (async, rst_n low): state IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, internal registers 0.
- States: IDLE, LOAD, ITER, DONE.
  - IDLE: start=1 → LOAD, operands captured into A (dividend) and B (divisor) registers.
  - LOAD: partial remainder R=0, Q=A, count=WIDTH; B==0 → DONE with zero-divide flag; else → ITER.
  - ITER: {R,Q} shifted left 1; trial T=R_shifted−B computed WIDTH+1 bits wide; T≥0 → R=T, Q[0]=1; else R restored, Q[0]=0; count decrements; count reaches 0 after this step → DONE.
  - DONE: done=1 for exactly one cycle; quotient=Q, remainder=R; → IDLE.
- Divide by zero: quotient = all ones, remainder = dividend, div_by_zero=1.
- start while busy: ignored, no effect on operation in progress.
- start held high continuously: new operation accepted on the first IDLE cycle after DONE.
- quotient/remainder/div_by_zero update only in DONE; cleared only by reset.
- Reset asserted mid-operation: immediate abort to IDLE, all outputs to reset values; no done pulse.

## Timing
- Start accepted at edge k (IDLE): LOAD during cycle k+1, ITER cycles k+2..k+WIDTH+1, done high in cycle k+WIDTH+2.
- Latency start→done: WIDTH+2 cycles (10 for WIDTH=8); divide by zero: 2 cycles.
- busy high from k+1 through done cycle; low in the cycle after done.
- Back-to-back throughput: one operation per WIDTH+3 cycles.
- Results stable and valid from done cycle onward.

## Configuration
- SEQ_DIVIDER_SIGNED_EN defined: operands and results are two's complement.
  - Magnitudes divided by the unsigned core; quotient is truncated toward zero; remainder takes the sign of the dividend.
  - Sign fix-up is applied in DONE, with no added latency.
  - Overflow case −2^(WIDTH−1)/−1: quotient = −2^(WIDTH−1), remainder 0.
  - Divide by zero: quotient = all ones, remainder = dividend.
- Undefined: purely unsigned operation; no sign logic synthesized.

## Structure
- Package seq_div_pkg:
  - state_t enum (IDLE, LOAD, ITER, DONE)
  - default WIDTH constant
  - control strobe struct (load, init, step, finish)
- Sub-module seq_div_datapath: A/B/R/Q registers, trial subtractor, counter, sign fix-up.
  - Driven by strobes from the FSM in seq_divider.
  - Returns cnt_zero and b_zero status to the FSM.

## Test plan
- WIDTH=8, 100/7:
  - done exactly 10 cycles after start edge; q=14, r=2, div_by_zero=0.
  - busy high for 10 cycles.
- 255/1 → q=255, r=0.
- 7/9 → q=0, r=7.
- 5/0:
  - done 2 cycles after start; q=0xFF, r=5, div_by_zero=1.
  - Next 6/3 → q=2, r=0, div_by_zero cleared.
- 100/7 started, then start pulsed with 50/5 during ITER:
  - Second request ignored; result q=14, r=2.
  - Outputs hold after done until the next accepted start.
- rst_n low in ITER cycle 4:
  - All outputs 0, no done pulse.
  - Subsequent 9/3 completes correctly with q=3, r=0.
- (SEQ_DIVIDER_SIGNED_EN)
  - −7/2 → q=0xFD, r=0xFF.
  - 7/−2 → q=0xFD, r=0x01.
  - −128/−1 → q=0x80, r=0.

Source files
------------

// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_div_pkg;

  // Default operand/result width in bits.
  localparam int SEQ_DIV_WIDTH_DEFAULT = 8;

  // Control FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_t;

  // Strobes from the control FSM to the datapath.
  //   load   : capture operands into A/B
  //   init   : clear R, seed Q with the dividend magnitude, preset the counter
  //   step   : one restoring shift/subtract iteration
  //   finish : present results and latch them into the hold registers
  typedef struct packed {
    logic load;
    logic init;
    logic step;
    logic finish;
  } ctrl_t;

endpackage

// File: rtl/seq_div_datapath.sv
// Datapath for seq_divider: operand registers, partial remainder/quotient,
// trial subtractor, iteration counter and result hold registers.
// Optional macro SEQ_DIVIDER_SIGNED_EN selects two's-complement operation.
module seq_div_datapath
  import seq_div_pkg::*;
#(
  parameter int WIDTH = SEQ_DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  ctrl_t            ctrl,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             cnt_zero,
  output logic             b_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] a_reg, b_reg, r_reg, q_reg;
  logic [WIDTH-1:0] quot_reg, rem_reg;
  logic             dbz_reg;
  logic [CW-1:0]    cnt_reg;

  logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;
  logic [WIDTH:0]   r_shift, trial;
  logic [WIDTH-1:0] res_q, res_r;

`ifdef SEQ_DIVIDER_SIGNED_EN
  // Divide magnitudes; quotient sign is the XOR of operand signs and the
  // remainder follows the dividend. -2^(W-1)/-1 falls out naturally.
  logic a_neg, b_neg;
  always_comb begin
    a_neg = a_reg[WIDTH-1];
    b_neg = b_reg[WIDTH-1];
    a_mag = a_neg ? -a_reg : a_reg;
    b_mag = b_neg ? -b_reg : b_reg;
    q_fix = (a_neg ^ b_neg) ? -q_reg : q_reg;
    r_fix = a_neg ? -r_reg : r_reg;
  end
`else
  // Unsigned build: magnitudes are the operands themselves.
  always_comb begin
    a_mag = a_reg;
    b_mag = b_reg;
    q_fix = q_reg;
    r_fix = r_reg;
  end
`endif

  // Trial subtraction on the left-shifted {R,Q}; bit WIDTH is the sign.
  always_comb begin
    r_shift = {r_reg, q_reg[WIDTH-1]};
    trial   = r_shift - {1'b0, b_mag};
  end

  // Status back to the FSM; cnt_zero flags the final iteration.
  assign b_zero   = (b_reg == '0);
  assign cnt_zero = (cnt_reg == CW'(1));

  // Final results; divide by zero overrides the arithmetic result.
  always_comb begin
    res_q = b_zero ? {WIDTH{1'b1}} : q_fix;
    res_r = b_zero ? a_reg : r_fix;
  end

  // Results show up combinationally in the done cycle, then come from the hold registers.
  assign quotient    = ctrl.finish ? res_q  : quot_reg;
  assign remainder   = ctrl.finish ? res_r  : rem_reg;
  assign div_by_zero = ctrl.finish ? b_zero : dbz_reg;

  // Operand, iteration and result-hold registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      r_reg    <= '0;
      q_reg    <= '0;
      cnt_reg  <= '0;
      quot_reg <= '0;
      rem_reg  <= '0;
      dbz_reg  <= 1'b0;
    end else begin
      if (ctrl.load) begin
        a_reg <= dividend;
        b_reg <= divisor;
      end
      if (ctrl.init) begin
        r_reg   <= '0;
        q_reg   <= a_mag;
        cnt_reg <= CW'(WIDTH);
      end
      if (ctrl.step) begin
        if (!trial[WIDTH]) begin
          r_reg <= trial[WIDTH-1:0];
          q_reg <= {q_reg[WIDTH-2:0], 1'b1};
        end else begin
          r_reg <= r_shift[WIDTH-1:0];
          q_reg <= {q_reg[WIDTH-2:0], 1'b0};
        end
        cnt_reg <= cnt_reg - CW'(1);
      end
      if (ctrl.finish) begin
        quot_reg <= res_q;
        rem_reg  <= res_r;
        dbz_reg  <= b_zero;
      end
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per cycle, start/done handshake.
// Optional macro SEQ_DIVIDER_SIGNED_EN selects two's-complement operation.
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int WIDTH = SEQ_DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_LOAD = 2'(LOAD);
  localparam logic [1:0] ST_ITER = 2'(ITER);
  localparam logic [1:0] ST_DONE = 2'(DONE);

  logic [1:0] state_reg, state_next;
  ctrl_t      ctrl;
  logic       cnt_zero, b_zero;

  // Next-state and strobe decode.
  always_comb begin
    state_next = state_reg;
    ctrl       = '0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          ctrl.load  = 1'b1;
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        ctrl.init  = 1'b1;
        state_next = b_zero ? ST_DONE : ST_ITER;
      end
      ST_ITER: begin
        ctrl.step = 1'b1;
        if (cnt_zero) state_next = ST_DONE;
      end
      ST_DONE: begin
        ctrl.finish = 1'b1;
        state_next  = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  assign busy = (state_reg != ST_IDLE);
  assign done = (state_reg == ST_DONE);

  seq_div_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk         (clk),
    .rst_n       (rst_n),
    .ctrl        (ctrl),
    .dividend    (dividend),
    .divisor     (divisor),
    .cnt_zero    (cnt_zero),
    .b_zero      (b_zero),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=8): vector table plus corner sequences.
module tb_seq_divider;

  localparam int W = 8;
  localparam int NV = 7;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           lat;
  } vec_t;

  vec_t vecs [NV];

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk8(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one start pulse that is sampled at the next rising edge.
  task automatic begin_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Wait for done (bounded); lat counts cycles from the accepting edge.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) chki("done_timeout", 0, 1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat, bc;
    begin_op(v.a, v.b);
    wait_done(lat, bc);
    $display("op %s: %02h / %02h -> q=%02h r=%02h dbz=%0d lat=%0d", tag, v.a, v.b,
             quotient, remainder, div_by_zero, lat);
    chki({tag, "_latency"}, lat, v.lat);
    chki({tag, "_busy_cycles"}, bc, v.lat);
    chk8({tag, "_quotient"}, quotient, v.q);
    chk8({tag, "_remainder"}, remainder, v.r);
    chki({tag, "_dbz"}, int'(div_by_zero), int'(v.z));
    @(negedge clk);
    chki({tag, "_done_single"}, int'(done), 0);
    chki({tag, "_busy_low_after"}, int'(busy), 0);
    chk8({tag, "_q_held"}, quotient, v.q);
  endtask

  initial begin
    int lat, bc, seen, d1, d2;

`ifdef SEQ_DIVIDER_SIGNED_EN
    vecs[0] = '{8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 10};  // -7/2
    vecs[1] = '{8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 10};  // 7/-2
    vecs[2] = '{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 10};  // -128/-1
    vecs[3] = '{8'h05, 8'h00, 8'hFF, 8'h05, 1'b1, 2};   // 5/0
    vecs[4] = '{8'h06, 8'h03, 8'h02, 8'h00, 1'b0, 10};  // 6/3 clears flag
    vecs[5] = '{8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 10};  // -100/-7
    vecs[6] = '{8'hFB, 8'h00, 8'hFF, 8'hFB, 1'b1, 2};   // -5/0
`else
    vecs[0] = '{8'd100, 8'd7,  8'd14,  8'd2, 1'b0, 10};
    vecs[1] = '{8'd255, 8'd1,  8'd255, 8'd0, 1'b0, 10};
    vecs[2] = '{8'd7,   8'd9,  8'd0,   8'd7, 1'b0, 10};
    vecs[3] = '{8'd5,   8'd0,  8'hFF,  8'd5, 1'b1, 2};
    vecs[4] = '{8'd6,   8'd3,  8'd2,   8'd0, 1'b0, 10};
    vecs[5] = '{8'd0,   8'd5,  8'd0,   8'd0, 1'b0, 10};
    vecs[6] = '{8'd200, 8'd13, 8'd15,  8'd5, 1'b0, 10};
`endif

    // Reset state.
    repeat (2) @(negedge clk);
    chki("rst_busy", int'(busy), 0);
    chki("rst_done", int'(done), 0);
    chk8("rst_quotient", quotient, 8'h00);
    chk8("rst_remainder", remainder, 8'h00);
    chki("rst_dbz", int'(div_by_zero), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chki("idle_busy", int'(busy), 0);

    // Table-driven vectors.
    for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Start pulsed during ITER must be ignored.
    begin_op(8'd100, 8'd7);
    repeat (3) @(negedge clk);
    dividend = 8'd50;
    divisor  = 8'd5;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc);
    $display("op ignore_start: 64 / 07 (start 32/05 mid-op) -> q=%02h r=%02h", quotient, remainder);
    chk8("ign_quotient", quotient, 8'd14);
    chk8("ign_remainder", remainder, 8'd2);
    repeat (5) @(negedge clk);
    chk8("ign_q_hold", quotient, 8'd14);
    chk8("ign_r_hold", remainder, 8'd2);
    chki("ign_idle", int'(busy), 0);

    // Reset asserted in ITER cycle 4 aborts the operation.
    begin_op(8'd100, 8'd7);
    repeat (5) @(negedge clk);
    chki("pre_abort_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    $display("op abort: reset during ITER -> busy=%0d q=%02h r=%02h", busy, quotient, remainder);
    chki("abort_busy", int'(busy), 0);
    chki("abort_done", int'(done), 0);
    chk8("abort_quotient", quotient, 8'h00);
    chk8("abort_remainder", remainder, 8'h00);
    chki("abort_dbz", int'(div_by_zero), 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      if (done) seen++;
    end
    chki("abort_no_done", seen, 0);
    run_vec('{8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 10}, "post_abort");

    // Start held high: back-to-back operations every W+3 cycles.
    @(negedge clk);
    dividend = 8'd6;
    divisor  = 8'd3;
    start    = 1'b1;
    d1 = 0;
    d2 = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (done) begin
        if (d1 == 0) d1 = i;
        else begin
          d2 = i;
          start = 1'b0;
          break;
        end
      end
    end
    $display("op held_start: 06 / 03 x2 -> done at %0d and %0d, q=%02h r=%02h", d1, d2, quotient, remainder);
    chki("held_first_latency", d1, W + 2);
    chki("held_spacing", d2 - d1, W + 3);
    chk8("held_quotient", quotient, 8'd2);
    chk8("held_remainder", remainder, 8'd0);
    repeat (3) @(negedge clk);
    chki("held_stops", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
